// File: rtl/axis_to_axil_master_pkg.sv
// Shared definitions for the command-stream to AXI-Lite master bridge:
// FSM state encoding, AXI response codes and command/response field offsets.
package axil_str_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WRITE   = 3'd1;
    localparam state_t ST_WR_RESP = 3'd2;
    localparam state_t ST_READ    = 3'd3;
    localparam state_t ST_RD_DATA = 3'd4;
    localparam state_t ST_RSP     = 3'd5;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    // Command layout, LSB first: wdata, addr, wstrb, rnw.
    function automatic int unsigned cmd_addr_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned cmd_strb_lsb(input int unsigned dw, input int unsigned aw);
        return dw + aw;
    endfunction

    function automatic int unsigned cmd_rnw_bit(input int unsigned dw, input int unsigned aw);
        return dw + aw + dw / 8;
    endfunction

    // Response layout, LSB first: rdata, resp[1:0], was_read.
    function automatic int unsigned rsp_resp_lsb(input int unsigned dw);
        return dw;
    endfunction

endpackage

// File: rtl/axis_to_axil_master.sv
// Converts a command stream into single outstanding AXI-Lite read/write
// transactions and reports each outcome on a response stream, strictly in order.
module axis_to_axil_master
    import axil_str_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int CMD_WIDTH      = 1 + AXI_DATA_WIDTH / 8 + AXI_ADDR_WIDTH + AXI_DATA_WIDTH,
    parameter int RSP_WIDTH      = AXI_DATA_WIDTH + 3
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic [CMD_WIDTH-1:0]        s_axis_cmd_tdata,
    input  logic                        s_axis_cmd_tvalid,
    output logic                        s_axis_cmd_tready,

    output logic [RSP_WIDTH-1:0]        m_axis_rsp_tdata,
    output logic                        m_axis_rsp_tvalid,
    input  logic                        m_axis_rsp_tready,

    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,
    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready,

    output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                        m_axil_arvalid,
    input  logic                        m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                  m_axil_rresp,
    input  logic                        m_axil_rvalid,
    output logic                        m_axil_rready
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB   = int'(cmd_addr_lsb(AXI_DATA_WIDTH));
    localparam int STRB_LSB   = int'(cmd_strb_lsb(AXI_DATA_WIDTH, AXI_ADDR_WIDTH));
    localparam int RNW_BIT    = int'(cmd_rnw_bit(AXI_DATA_WIDTH, AXI_ADDR_WIDTH));

    state_t                    state;
    logic                      cmd_rnw;
    logic [STRB_WIDTH-1:0]     cmd_strb;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [AXI_DATA_WIDTH-1:0] cmd_data;
    logic                      aw_done;
    logic                      w_done;

    assign cmd_rnw  = s_axis_cmd_tdata[RNW_BIT];
    assign cmd_strb = s_axis_cmd_tdata[STRB_LSB +: STRB_WIDTH];
    assign cmd_addr = s_axis_cmd_tdata[ADDR_LSB +: AXI_ADDR_WIDTH];
    assign cmd_data = s_axis_cmd_tdata[0 +: AXI_DATA_WIDTH];

    // A channel counts as done if it already handshook or handshakes on this edge.
    assign aw_done = !m_axil_awvalid || m_axil_awready;
    assign w_done  = !m_axil_wvalid  || m_axil_wready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state             <= ST_IDLE;
            s_axis_cmd_tready <= 1'b0;
            m_axis_rsp_tdata  <= '0;
            m_axis_rsp_tvalid <= 1'b0;
            m_axil_awaddr     <= '0;
            m_axil_awvalid    <= 1'b0;
            m_axil_wdata      <= '0;
            m_axil_wstrb      <= '0;
            m_axil_wvalid     <= 1'b0;
            m_axil_bready     <= 1'b0;
            m_axil_araddr     <= '0;
            m_axil_arvalid    <= 1'b0;
            m_axil_rready     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_axis_cmd_tready && s_axis_cmd_tvalid) begin
                        s_axis_cmd_tready <= 1'b0;
                        if (cmd_rnw) begin
                            m_axil_araddr  <= cmd_addr;
                            m_axil_arvalid <= 1'b1;
                            state          <= ST_READ;
                        end else begin
                            m_axil_awaddr  <= cmd_addr;
                            m_axil_wdata   <= cmd_data;
                            m_axil_wstrb   <= cmd_strb;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= ST_WRITE;
                        end
                    end else begin
                        s_axis_cmd_tready <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axil_bready <= 1'b1;
                        state         <= ST_WR_RESP;
                    end
                end

                ST_WR_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready     <= 1'b0;
                        m_axis_rsp_tdata  <= {1'b0, m_axil_bresp, {AXI_DATA_WIDTH{1'b0}}};
                        m_axis_rsp_tvalid <= 1'b1;
                        state             <= ST_RSP;
                    end
                end

                ST_READ: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= ST_RD_DATA;
                    end
                end

                ST_RD_DATA: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready     <= 1'b0;
                        m_axis_rsp_tdata  <= {1'b1, m_axil_rresp, m_axil_rdata};
                        m_axis_rsp_tvalid <= 1'b1;
                        state             <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (m_axis_rsp_tready) begin
                        m_axis_rsp_tvalid <= 1'b0;
                        s_axis_cmd_tready <= 1'b1;
                        state             <= ST_IDLE;
                    end
                end

                default: begin
                    state             <= ST_IDLE;
                    s_axis_cmd_tready <= 1'b0;
                    m_axis_rsp_tvalid <= 1'b0;
                    m_axil_awvalid    <= 1'b0;
                    m_axil_wvalid     <= 1'b0;
                    m_axil_bready     <= 1'b0;
                    m_axil_arvalid    <= 1'b0;
                    m_axil_rready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_to_axil_master.sv
// Randomised bench for axis_to_axil_master: a memory-backed AXI-Lite slave with
// configurable waits, a response sink with back-pressure, and a reference memory model.
module tb_axis_to_axil_master;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int CMD_W = 1 + DW / 8 + AW + DW;
    localparam int RSP_W = DW + 3;

    logic             aclk = 1'b0;
    logic             areset;
    logic [CMD_W-1:0] s_axis_cmd_tdata;
    logic             s_axis_cmd_tvalid;
    logic             s_axis_cmd_tready;
    logic [RSP_W-1:0] m_axis_rsp_tdata;
    logic             m_axis_rsp_tvalid;
    logic             m_axis_rsp_tready;
    logic [AW-1:0]    m_axil_awaddr;
    logic             m_axil_awvalid;
    logic             m_axil_awready;
    logic [DW-1:0]    m_axil_wdata;
    logic [DW/8-1:0]  m_axil_wstrb;
    logic             m_axil_wvalid;
    logic             m_axil_wready;
    logic [1:0]       m_axil_bresp;
    logic             m_axil_bvalid;
    logic             m_axil_bready;
    logic [AW-1:0]    m_axil_araddr;
    logic             m_axil_arvalid;
    logic             m_axil_arready;
    logic [DW-1:0]    m_axil_rdata;
    logic [1:0]       m_axil_rresp;
    logic             m_axil_rvalid;
    logic             m_axil_rready;

    axis_to_axil_master #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_axis_cmd_tdata  (s_axis_cmd_tdata),
        .s_axis_cmd_tvalid (s_axis_cmd_tvalid),
        .s_axis_cmd_tready (s_axis_cmd_tready),
        .m_axis_rsp_tdata  (m_axis_rsp_tdata),
        .m_axis_rsp_tvalid (m_axis_rsp_tvalid),
        .m_axis_rsp_tready (m_axis_rsp_tready),
        .m_axil_awaddr     (m_axil_awaddr),
        .m_axil_awvalid    (m_axil_awvalid),
        .m_axil_awready    (m_axil_awready),
        .m_axil_wdata      (m_axil_wdata),
        .m_axil_wstrb      (m_axil_wstrb),
        .m_axil_wvalid     (m_axil_wvalid),
        .m_axil_wready     (m_axil_wready),
        .m_axil_bresp      (m_axil_bresp),
        .m_axil_bvalid     (m_axil_bvalid),
        .m_axil_bready     (m_axil_bready),
        .m_axil_araddr     (m_axil_araddr),
        .m_axil_arvalid    (m_axil_arvalid),
        .m_axil_arready    (m_axil_arready),
        .m_axil_rdata      (m_axil_rdata),
        .m_axil_rresp      (m_axil_rresp),
        .m_axil_rvalid     (m_axil_rvalid),
        .m_axil_rready     (m_axil_rready)
    );

    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Slave behaviour: response code comes from address bits [9:8], storage index from [7:2].
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[9:8];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0]      ref_mem [64];
    logic [RSP_W-1:0] exp_rsp_q [$];
    logic [31:0]      exp_aw_q [$];
    logic [35:0]      exp_w_q [$];
    logic [31:0]      exp_ar_q [$];
    int unsigned      acc_q [$];

    task automatic model_accept(input logic rnw, input logic [3:0] strb,
                                input logic [31:0] addr, input logic [31:0] data);
        if (rnw) begin
            exp_rsp_q.push_back({1'b1, resp_of(addr), ref_mem[addr[7:2]]});
            exp_ar_q.push_back(addr);
        end else begin
            ref_mem[addr[7:2]] = merge(ref_mem[addr[7:2]], data, strb);
            exp_rsp_q.push_back({1'b0, resp_of(addr), 32'h0});
            exp_aw_q.push_back(addr);
            exp_w_q.push_back({strb, data});
        end
        acc_q.push_back(cyc + 1);
    endtask

    // ---------------- slave configuration ----------------
    int unsigned cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r, sink_hold;
    bit          cfg_rand, sink_rand, chk_lat;
    int unsigned rsp_count = 0;

    function automatic int unsigned pick(input int unsigned fixed);
        return cfg_rand ? $urandom_range(0, 3) : fixed;
    endfunction

    // ---------------- AXI-Lite slave ----------------
    logic [31:0] smem [64];
    logic        aw_got, w_got, wr_both, wr_busy, b_fire;
    logic        ar_got, r_ph, rd_busy, r_fire;
    int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    task automatic slave_clear();
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0;
        m_axil_rresp = 0; m_axil_rdata = 0;
        aw_got = 0; w_got = 0; wr_both = 0; wr_busy = 0; b_fire = 0;
        ar_got = 0; r_ph = 0; rd_busy = 0; r_fire = 0;
    endtask

    initial begin
        slave_clear();
        forever begin
            @(negedge aclk);
            if (areset) begin
                slave_clear();
                continue;
            end
            if (b_fire) begin
                m_axil_bvalid = 0; b_fire = 0; wr_busy = 0;
                aw_got = 0; w_got = 0; wr_both = 0;
            end
            if (r_fire) begin
                m_axil_rvalid = 0; r_fire = 0; rd_busy = 0; ar_got = 0; r_ph = 0;
            end
            m_axil_awready = 0;
            m_axil_wready  = 0;
            m_axil_arready = 0;

            if (!wr_busy && (m_axil_awvalid || m_axil_wvalid)) begin
                wr_busy = 1;
                aw_wait = pick(cfg_aw); w_wait = pick(cfg_w); b_wait = pick(cfg_b);
                chk("aw_w_together", m_axil_awvalid, m_axil_wvalid);
            end
            if (wr_busy) begin
                if (aw_got && w_got && !wr_both) begin
                    wr_both = 1;
                    smem[s_awaddr[7:2]] = merge(smem[s_awaddr[7:2]], s_wdata, s_wstrb);
                end
                if (aw_got) chk("aw_once", m_axil_awvalid, 0);
                if (w_got)  chk("w_once", m_axil_wvalid, 0);
                if (!wr_both) chk("bready_early", m_axil_bready, 0);
                if (wr_both && !m_axil_bvalid) begin
                    if (b_wait == 0) begin
                        m_axil_bvalid = 1;
                        m_axil_bresp  = resp_of(s_awaddr);
                    end else b_wait--;
                end
                if (m_axil_bvalid && m_axil_bready) b_fire = 1;
                if (!aw_got && m_axil_awvalid) begin
                    if (aw_wait == 0) begin
                        m_axil_awready = 1; aw_got = 1; s_awaddr = m_axil_awaddr;
                        if (exp_aw_q.size() == 0) chk("aw_expected", exp_aw_q.size(), 1);
                        else chk("awaddr", m_axil_awaddr, exp_aw_q.pop_front());
                    end else aw_wait--;
                end
                if (!w_got && m_axil_wvalid) begin
                    if (w_wait == 0) begin
                        m_axil_wready = 1; w_got = 1;
                        s_wdata = m_axil_wdata; s_wstrb = m_axil_wstrb;
                        if (exp_w_q.size() == 0) chk("w_expected", exp_w_q.size(), 1);
                        else chk("wstrb_wdata", {m_axil_wstrb, m_axil_wdata}, exp_w_q.pop_front());
                    end else w_wait--;
                end
            end

            if (!rd_busy && m_axil_arvalid) begin
                rd_busy = 1;
                ar_wait = pick(cfg_ar); r_wait = pick(cfg_r);
            end
            if (rd_busy) begin
                if (ar_got && !r_ph) r_ph = 1;
                if (ar_got) chk("ar_once", m_axil_arvalid, 0);
                if (!r_ph) chk("rready_early", m_axil_rready, 0);
                if (r_ph && !m_axil_rvalid) begin
                    if (r_wait == 0) begin
                        m_axil_rvalid = 1;
                        m_axil_rdata  = smem[s_araddr[7:2]];
                        m_axil_rresp  = resp_of(s_araddr);
                    end else r_wait--;
                end
                if (m_axil_rvalid && m_axil_rready) r_fire = 1;
                if (!ar_got && m_axil_arvalid) begin
                    if (ar_wait == 0) begin
                        m_axil_arready = 1; ar_got = 1; s_araddr = m_axil_araddr;
                        if (exp_ar_q.size() == 0) chk("ar_expected", exp_ar_q.size(), 1);
                        else chk("araddr", m_axil_araddr, exp_ar_q.pop_front());
                    end else ar_wait--;
                end
            end
            if (wr_busy || rd_busy) chk("one_txn", wr_busy && rd_busy, 0);
        end
    end

    // ---------------- response sink ----------------
    logic [RSP_W-1:0] held;
    bit               seen;
    int unsigned      waited, want, acc;

    initial begin
        m_axis_rsp_tready = 0;
        seen = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                m_axis_rsp_tready = 0;
                seen = 0;
                continue;
            end
            if (m_axis_rsp_tvalid) begin
                chk("cmd_tready_in_rsp", s_axis_cmd_tready, 0);
                if (seen) chk("rsp_stable", m_axis_rsp_tdata, held);
                else begin
                    seen = 1; held = m_axis_rsp_tdata; waited = 0;
                    want = sink_rand ? $urandom_range(0, 3) : sink_hold;
                end
                if (waited >= want) begin
                    m_axis_rsp_tready = 1;
                    seen = 0;
                    rsp_count++;
                    if (exp_rsp_q.size() == 0) chk("rsp_expected", exp_rsp_q.size(), 1);
                    else chk("rsp_data", m_axis_rsp_tdata, exp_rsp_q.pop_front());
                    if (acc_q.size() != 0) begin
                        acc = acc_q.pop_front();
                        if (chk_lat) chk("latency", cyc + 1 - acc, 3);
                    end
                end else begin
                    m_axis_rsp_tready = 0;
                    waited++;
                end
            end else begin
                m_axis_rsp_tready = sink_rand ? 1'($urandom % 2) : 1'b0;
            end
        end
    end

    // ---------------- command driver ----------------
    task automatic send(input logic rnw, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] data);
        int unsigned n = 0;
        s_axis_cmd_tdata  = {rnw, strb, addr, data};
        s_axis_cmd_tvalid = 1;
        while (!s_axis_cmd_tready && n < 400) begin
            @(negedge aclk);
            n++;
        end
        if (!s_axis_cmd_tready) begin
            chk("cmd_accept", s_axis_cmd_tready, 1);
            s_axis_cmd_tvalid = 0;
            return;
        end
        model_accept(rnw, strb, addr, data);
        @(negedge aclk);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_rsp_q.size() != 0 || !s_axis_cmd_tready) && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        chk("drained", {exp_rsp_q.size() == 0, s_axis_cmd_tready}, 2'b11);
    endtask

    task automatic set_cfg(input int unsigned aw, input int unsigned w, input int unsigned b,
                           input int unsigned ar, input int unsigned r, input int unsigned hold);
        cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_ar = ar; cfg_r = r; sink_hold = hold;
        cfg_rand = 0; sink_rand = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    logic [31:0] saved [64];
    logic [31:0] tmp, addr;
    int unsigned rc, n;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 0;
            smem[i]    = 0;
        end
        set_cfg(0, 0, 0, 0, 0, 0);
        chk_lat = 0;
        areset = 1;
        s_axis_cmd_tvalid = 0;
        s_axis_cmd_tdata  = '0;
        repeat (3) @(negedge aclk);
        chk("rst_valids", {s_axis_cmd_tready, m_axis_rsp_tvalid, m_axil_awvalid, m_axil_wvalid,
                           m_axil_bready, m_axil_arvalid, m_axil_rready}, 0);
        chk("rst_rsp", m_axis_rsp_tdata, 0);
        chk("rst_addr", {m_axil_awaddr, m_axil_araddr}, 0);
        chk("rst_wdata", {m_axil_wstrb, m_axil_wdata}, 0);
        areset = 0;
        n = 0;
        while (!s_axis_cmd_tready && n < 10) begin @(negedge aclk); n++; end
        chk("tready_after_rst", s_axis_cmd_tready, 1);

        // Zero-wait write and reads with minimum latency.
        chk_lat = 1;
        send(0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        s_axis_cmd_tvalid = 0;
        drain();
        send(0, 4'hF, 32'h0000_0024, 32'h1234_5678);
        s_axis_cmd_tvalid = 0;
        drain();
        send(1, 4'h0, 32'h0000_0010, 32'h0);
        s_axis_cmd_tvalid = 0;
        drain();
        chk_lat = 0;

        // Read with delayed arready and rvalid.
        set_cfg(0, 0, 0, 2, 3, 0);
        send(1, 4'h0, 32'h0000_0024, 32'h0);
        s_axis_cmd_tvalid = 0;
        drain();

        // Split acceptance: w first, aw two cycles later.
        set_cfg(2, 0, 1, 0, 0, 0);
        send(0, 4'b0101, 32'h0000_0030, 32'hCAFE_F00D);
        s_axis_cmd_tvalid = 0;
        drain();
        set_cfg(0, 3, 0, 0, 0, 0);
        send(0, 4'b1010, 32'h0000_0030, 32'h1111_2222);
        s_axis_cmd_tvalid = 0;
        drain();

        // Error responses with sink back-pressure.
        set_cfg(0, 0, 0, 0, 1, 5);
        send(1, 4'h0, 32'h0000_0224, 32'h0);
        s_axis_cmd_tvalid = 0;
        drain();
        send(0, 4'hF, 32'h0000_0314, 32'h0BAD_0BAD);
        s_axis_cmd_tvalid = 0;
        drain();

        // Back-to-back alternating with tvalid held high, including all-zero strobe.
        set_cfg(0, 0, 0, 0, 0, 0);
        chk_lat = 1;
        send(0, 4'h3, 32'h0000_0040, 32'hAABB_CCDD);
        send(1, 4'h0, 32'h0000_0040, 32'h0);
        send(0, 4'h0, 32'h0000_0140, 32'hFFFF_FFFF);
        send(1, 4'h0, 32'h0000_0140, 32'h0);
        s_axis_cmd_tvalid = 0;
        drain();
        chk_lat = 0;

        // Reset while awvalid is pending: transaction abandoned, no response.
        set_cfg(40, 40, 0, 0, 0, 0);
        saved = ref_mem;
        send(0, 4'hF, 32'h0000_003C, 32'hA5A5_5A5A);
        s_axis_cmd_tvalid = 0;
        chk("pre_rst_awvalid", m_axil_awvalid, 1);
        areset = 1;
        @(negedge aclk);
        chk("midrst_valids", {s_axis_cmd_tready, m_axis_rsp_tvalid, m_axil_awvalid, m_axil_wvalid,
                              m_axil_bready, m_axil_arvalid, m_axil_rready}, 0);
        areset = 0;
        ref_mem = saved;
        void'(exp_rsp_q.pop_back());
        void'(acc_q.pop_back());
        exp_aw_q.delete();
        exp_w_q.delete();
        rc = rsp_count;
        n = 0;
        while (!s_axis_cmd_tready && n < 10) begin @(negedge aclk); n++; end
        chk("tready_after_midrst", s_axis_cmd_tready, 1);
        repeat (10) @(negedge aclk);
        chk("no_rsp_after_rst", rsp_count, rc);
        set_cfg(0, 0, 0, 0, 0, 0);
        send(1, 4'h0, 32'h0000_003C, 32'h0);
        s_axis_cmd_tvalid = 0;
        drain();

        // Random traffic against the reference memory.
        cfg_rand = 1;
        sink_rand = 1;
        for (int i = 0; i < 60; i++) begin
            tmp  = $urandom;
            addr = {tmp[31:10], 2'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 7)), 2'b00};
            send(1'($urandom % 2), ($urandom % 8 == 0) ? 4'h0 : 4'($urandom), addr, $urandom);
            if ($urandom % 3 == 0) begin
                s_axis_cmd_tvalid = 0;
                repeat ($urandom_range(1, 3)) @(negedge aclk);
            end
        end
        s_axis_cmd_tvalid = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
